// File: rtl/word_stacker.sv
// Collects NUM_WORDS stream words into one block, first word in the MSB slot.
// Define WORD_STACKER_BSWAP_EN to byte-reverse each word before it is stored.
//
// state | meaning
// FILL  | collecting words; cnt_q = number of words of the partial block held
// FULL  | block complete and presented on word_o, waiting for ready_i
module word_stacker #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clr_i,
  input  logic                          enable_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [WORD_W-1:0]             word_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [WORD_W*NUM_WORDS-1:0]   word_o,
  output logic [$clog2(NUM_WORDS)-1:0]  cnt_o
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS);
  localparam int unsigned BLK_W = WORD_W * NUM_WORDS;

  typedef enum logic {FILL, FULL} state_e;

  state_e               state_q, state_d;
  logic [BLK_W-1:0]     stack_r, stack_d;
  logic [CNT_W-1:0]     cnt_r, cnt_d;
  logic [WORD_W-1:0]    word_in;
  logic                 acc, drn;

`ifdef WORD_STACKER_BSWAP_EN
  function automatic logic [WORD_W-1:0] bswap(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < int'(WORD_W / 8); b++) begin
      r[(int'(WORD_W / 8) - 1 - b) * 8 +: 8] = w[b * 8 +: 8];
    end
    return r;
  endfunction

  assign word_in = bswap(word_i);
`else
  assign word_in = word_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      stack_r <= '0;
      cnt_r   <= '0;
    end else begin
      state_q <= state_d;
      stack_r <= stack_d;
      cnt_r   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stack_d = stack_r;
    cnt_d   = cnt_r;
    if (clr_i) begin
      state_d = FILL;
      stack_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (acc) begin
            for (int k = 0; k < int'(NUM_WORDS); k++) begin
              if (cnt_r == CNT_W'(k)) begin
                stack_d[(int'(NUM_WORDS) - k) * int'(WORD_W) - 1 -: WORD_W] = word_in;
              end
            end
            if (cnt_r == CNT_W'(NUM_WORDS - 1)) begin
              state_d = FULL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_r + CNT_W'(1);
            end
          end
        end
        FULL: begin
          // acc can only occur here together with drn: drain and refill slot 0
          if (drn) begin
            state_d = FILL;
            if (acc) begin
              stack_d[BLK_W-1 -: WORD_W] = word_in;
              cnt_d = CNT_W'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_comb begin
    valid_o = enable_i & (state_q == FULL);
    ready_o = enable_i & ((state_q == FILL) | ready_i);
    acc     = valid_i & ready_o;
    drn     = valid_o & ready_i;
    word_o  = stack_r;
    cnt_o   = cnt_r;
  end

endmodule

// File: tb/tb_word_stacker.sv
// Directed scenarios plus a randomized run against a queue-based model of
// word_stacker (WORD_W=32, NUM_WORDS=4).
module tb_word_stacker;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         clr_i;
  logic         enable_i;
  logic         valid_i;
  logic         ready_o;
  logic [31:0]  word_i;
  logic         valid_o;
  logic         ready_i;
  logic [127:0] word_o;
  logic [1:0]   cnt_o;

  int errors = 0;
  int checks = 0;

  word_stacker #(.WORD_W(32), .NUM_WORDS(4)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr_i),
    .enable_i (enable_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .word_i   (word_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .word_o   (word_o),
    .cnt_o    (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Stored form of a word as the block should hold it.
  function automatic logic [31:0] st(input logic [31:0] w);
`ifdef WORD_STACKER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] blk(input logic [31:0] a, b, c, d);
    return {st(a), st(b), st(c), st(d)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    word_i  = w;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  logic [31:0] q[$];
  logic        exp_valid, exp_ready, en_r, val_r, rdy_r, clr_r;
  logic [31:0] w_r;

  initial begin
    rst_ni = 1'b0; clr_i = 1'b0; enable_i = 1'b0; valid_i = 1'b0;
    word_i = '0; ready_i = 1'b0;
    #1;
    chk("rst_ready_dis", ready_o, 0);
    enable_i = 1'b1;
    #1;
    chk("rst_word", word_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_ready", ready_o, 1);
    #12 rst_ni = 1'b1;
    tick();

    // Basic fill with ready_i low
    begin
      logic [31:0] w[4];
      w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
      for (int i = 0; i < 4; i++) begin
        word_i = w[i]; valid_i = 1'b1;
        #1;
        chk("fill_cnt", cnt_o, 128'(i));
        chk("fill_ready", ready_o, 1);
        chk("fill_valid", valid_o, 0);
        tick();
      end
      valid_i = 1'b0;
      chk("fill_valid_done", valid_o, 1);
      chk("fill_cnt_done", cnt_o, 0);
      chk("fill_ready_full", ready_o, 0);
      chk("fill_block", word_o, blk(w[0], w[1], w[2], w[3]));
      ready_i = 1'b1;
      #1;
      chk("fill_ready_path", ready_o, 1);
      tick();
      chk("fill_drained", valid_o, 0);
    end

    // Back-to-back stream, ready_i held high
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      word_i = 32'(i); valid_i = 1'b1;
      #1;
      chk("b2b_ready", ready_o, 1);
      if (i == 5) begin
        chk("b2b_valid1", valid_o, 1);
        chk("b2b_block1", word_o, blk(1, 2, 3, 4));
      end
      tick();
    end
    valid_i = 1'b0;
    chk("b2b_valid2", valid_o, 1);
    chk("b2b_block2", word_o, blk(5, 6, 7, 8));
    tick();
    chk("b2b_drained", valid_o, 0);

    // Backpressure on a full block
    ready_i = 1'b0;
    send(32'hA0A1A2A3); send(32'hB0B1B2B3); send(32'hC0C1C2C3); send(32'hD0D1D2D3);
    word_i = 32'hDEADBEEF; valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", ready_o, 0);
      chk("bp_valid", valid_o, 1);
      chk("bp_stable", word_o, blk(32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3));
      tick();
    end
    ready_i = 1'b1;
    #1;
    chk("bp_ready_rise", ready_o, 1);
    tick();
    ready_i = 1'b0; valid_i = 1'b0;
    chk("bp_valid_after", valid_o, 0);
    chk("bp_cnt_after", cnt_o, 1);
    chk("bp_slot0", word_o,
        {st(32'hDEADBEEF), st(32'hB0B1B2B3), st(32'hC0C1C2C3), st(32'hD0D1D2D3)});

    // Enable gating mid-block
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    send(32'h11111111); send(32'h22222222);
    enable_i = 1'b0; valid_i = 1'b1; word_i = 32'hBADBAD00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("en_ready", ready_o, 0);
      chk("en_valid", valid_o, 0);
      tick();
      chk("en_cnt", cnt_o, 2);
    end
    enable_i = 1'b1;
    send(32'h33333333); send(32'h44444444);
    chk("en_valid_done", valid_o, 1);
    chk("en_block", word_o, blk(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444));
    ready_i = 1'b1; tick(); ready_i = 1'b0;

    // Clear mid-block drops the word presented with it
    send(32'h01010101); send(32'h02020202); send(32'h03030303);
    clr_i = 1'b1; valid_i = 1'b1; word_i = 32'hBADC0DE0;
    tick();
    clr_i = 1'b0; valid_i = 1'b0;
    chk("clr_cnt", cnt_o, 0);
    chk("clr_word", word_o, 0);
    chk("clr_valid", valid_o, 0);

    // Asynchronous reset mid-block
    send(32'h05050505); send(32'h06060606); send(32'h07070707);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_cnt", cnt_o, 0);
    chk("arst_word", word_o, 0);
    chk("arst_valid", valid_o, 0);
    chk("arst_ready", ready_o, 1);
    #1 rst_ni = 1'b1;
    tick();

    // Randomized run against a queue of held words
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      en_r  = ($urandom_range(0, 9) != 0);
      val_r = $urandom_range(0, 1) == 1;
      rdy_r = $urandom_range(0, 2) != 0;
      clr_r = ($urandom_range(0, 59) == 0);
      w_r   = $urandom;
      enable_i = en_r; valid_i = val_r; ready_i = rdy_r; clr_i = clr_r; word_i = w_r;
      #1;
      exp_valid = en_r && (q.size() == 4);
      exp_ready = en_r && ((q.size() < 4) || rdy_r);
      chk("rnd_valid", valid_o, exp_valid);
      chk("rnd_ready", ready_o, exp_ready);
      chk("rnd_cnt", cnt_o, 128'(q.size() % 4));
      if (exp_valid) chk("rnd_block", word_o, {q[0], q[1], q[2], q[3]});
      if (clr_r) begin
        q.delete();
      end else begin
        if (exp_valid && rdy_r) repeat (4) void'(q.pop_front());
        if (val_r && exp_ready) q.push_back(st(w_r));
      end
      tick();
    end
    clr_i = 1'b0; valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_stacker.md
Name: word_stacker

Overview:
- Input stage of the AES HWPE datapath. Collects NUM_WORDS consecutive WORD_W-bit stream words (4 x 32 bit by default) into one block (128 bit by default) for the cipher core.
- It is the mirror of the output-side 128-to-32 unstacker, using the same valid/ready, clr_i and enable_i conventions.
- Supports back-to-back operation: one word per cycle is sustained while blocks drain.

Parameters:
- WORD_W, 32, width of one input stream word.
- NUM_WORDS, 4, words per block; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous soft clear; priority over enable_i.
- enable_i  in  1  stage enable; when low, handshakes are masked and state is frozen.
- valid_i  in  1  input word valid.
- ready_o  out  1  input word accepted when valid_i & ready_o.
- word_i  in  WORD_W  input word.
- valid_o  out  1  assembled block valid.
- ready_i  in  1  downstream accepts block when valid_o & ready_i.
- word_o  out  WORD_W*NUM_WORDS  assembled block.
- cnt_o  out  $clog2(NUM_WORDS)  number of words of the current partial block held.

Behaviour:
- Storage:
  - Block register stack_r (WORD_W*NUM_WORDS bits), slot counter cnt_r, state register.
  - States: FILL, FULL.
- Slot order:
  - The first word of a block lands in the MSB slot, stack_r[NUM_WORDS*WORD_W-1 -: WORD_W]; the last word lands in [WORD_W-1:0].
  - Slot index k is written at [(NUM_WORDS-k)*WORD_W-1 -: WORD_W].
- Combinational outputs:
  - word_o = stack_r, always.
  - cnt_o = cnt_r.
  - valid_o = enable_i & (state==FULL).
  - ready_o = enable_i & ((state==FILL) | ready_i).
- Accept and drain events:
  - acc = valid_i & ready_o.
  - drn = valid_o & ready_i.
- FILL state:
  - On acc, write word_i into slot cnt_r.
  - If cnt_r==NUM_WORDS-1: go to FULL, cnt_r <= 0.
  - Otherwise cnt_r <= cnt_r+1.
  - Without acc, hold.
- FULL state:
  - drn & ~acc: go to FILL.
  - drn & acc: write word_i into slot 0, cnt_r <= 1, go to FILL. This is the same-cycle drain-and-refill case.
  - No drn: hold; stack_r is stable and ready_o=0.
- Latency and throughput:
  - valid_o asserts the cycle after the NUM_WORDS-th accept.
  - Sustained throughput is 1 word/cycle; a block is presented every NUM_WORDS cycles.
  - ready_o depends combinationally on ready_i in FULL. This is a deliberate, documented ready path.
- Stale data: slots not yet rewritten keep old data. word_o is meaningful only while valid_o=1.
- enable_i low: ready_o=0 and valid_o=0; all registers hold, including a partial block.
- clr_i (when not in reset):
  - Next cycle: stack_r=0, cnt_r=0, state=FILL.
  - Any partial or full block is discarded.
  - A word presented in the clr_i cycle is dropped.
- Reset values: stack_r=0, cnt_r=0, state=FILL. Hence word_o=0, valid_o=0, cnt_o=0, ready_o=enable_i.
- Reset asserted mid-block: the partial block is lost and cnt_o returns to 0 asynchronously.
- valid_i held with ready_o=0: the word must be held by upstream (standard stream rule); no loss.

Optional Feature:
- Macro: WORD_STACKER_BSWAP_EN.
- When defined, each accepted word is byte-reversed before storage: word_i[7:0] goes to the slot MSB byte, and so on. This converts little-endian TCDM words to AES big-endian state order. WORD_W must be a multiple of 8.
- When undefined, words are stored unmodified.
- Handshake and timing are identical in both cases.

Test Plan:
- Basic fill:
  - Stimulus: enable=1, ready_i=0; send 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
  - Response: valid_o=1 one cycle after the 4th accept; word_o=0x00112233_44556677_8899AABB_CCDDEEFF; ready_o=0 while ready_i=0; cnt_o steps 0,1,2,3,0.
- Back-to-back stream:
  - Stimulus: 8 words 0x1..0x8 on consecutive cycles with ready_i=1 constantly.
  - Response: 2 blocks, 0x1_2_3_4 and 0x5_6_7_8 (each 32-bit slot zero-extended); ready_o never deasserts; the 5th word is accepted in the same cycle as the first block drains.
- Backpressure: block FULL, ready_i=0 for 5 cycles, valid_i=1 with word 0xDEADBEEF -> word_o stable, word not accepted, then accepted into slot 0 on the cycle ready_i rises.
- Enable gating: after 2 words (cnt_o=2), enable_i=0 for 3 cycles with valid_i=1 -> ready_o=0, cnt_o stays 2; resuming and sending 2 words completes the correct block.
- Clear and reset mid-block:
  - Stimulus: 3 words, then clr_i pulse while valid_i=1.
  - Response: cnt_o=0, word_o=0, valid_o=0; the dropped word does not appear.
  - Repeat with rst_ni low: same values asynchronously.
- With WORD_STACKER_BSWAP_EN: 4 words 0x00112233 -> word_o slot 0 = 0x33221100 and all slots are byte-reversed; the handshake trace matches test 1 exactly.
